// File: rtl/clock_period_meter.sv
// clock_period_meter: measures the period and high time of a slow asynchronous
// clock (in_clk) in cycles of clk. One result per full in_clk period, delivered
// through a valid/ready handshake with sticky overrun and timeout flags.
module clock_period_meter #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_clk,
  input  logic             enable,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             overrun,
  output logic             timeout
);

  typedef enum logic {SEEK, MEASURE} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] high;
  } result_t;

  // Last count value before the counter would overflow: 2^WIDTH-2.
  localparam logic [WIDTH-1:0] CNT_LAST = {{(WIDTH-1){1'b1}}, 1'b0};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   sync_lvl;
  logic                   rise;
  logic                   fall;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hcnt_q, hcnt_d;
  logic [WIDTH-1:0] cnt_inc;
  logic             capture;
  logic             set_timeout;
  result_t          result_q;

  assign sync_lvl = sync_q[SYNC_STAGES-1];
  assign rise     = sync_lvl & ~prev_q;
  assign fall     = ~sync_lvl & prev_q;
  assign cnt_inc  = cnt_q + ONE;

  // Synchronizer chain plus one edge-detect flop on in_clk.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_clk};
      prev_q <= sync_lvl;
    end
  end

  // FSM state and measurement counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= SEEK;
      cnt_q   <= '0;
      hcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hcnt_q  <= hcnt_d;
    end
  end

  // Next-state logic: SEEK arms on the first rise, MEASURE closes a period on
  // each later rise. Disabling wins over everything and drops the partial count.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hcnt_d      = hcnt_q;
    capture     = 1'b0;
    set_timeout = 1'b0;
    case (state_q)
      SEEK: begin
        if (enable && rise) begin
          cnt_d   = '0;
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (!enable) begin
          state_d = SEEK;
          cnt_d   = '0;
        end else if (rise) begin
          capture = 1'b1;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          // No rise within 2^WIDTH-1 cycles: give up and rearm.
          set_timeout = 1'b1;
          state_d     = SEEK;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_inc;
          if (fall) hcnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = SEEK;
        cnt_d   = '0;
      end
    endcase
  end

  // Result register with valid/ready handshake; overrun/timeout are sticky.
  always_ff @(posedge clk) begin
    if (!reset) begin
      result_q     <= '0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      if (capture) begin
        result_q.period <= cnt_inc;
        result_q.high   <= hcnt_q;
        result_valid    <= 1'b1;
        // Same-cycle consumption is not an overrun.
        if (result_valid && !result_ready) overrun <= 1'b1;
      end else if (result_valid && result_ready) begin
        result_valid <= 1'b0;
      end
      if (set_timeout) timeout <= 1'b1;
    end
  end

  assign period    = result_q.period;
  assign high_time = result_q.high;

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed bench for clock_period_meter (WIDTH=8, SYNC_STAGES=2). in_clk is
// generated on the falling edge of clk, so detection latency is exact.
`timescale 1ns/1ps
module tb_clock_period_meter;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             in_clk = 1'b0;
  logic             enable = 1'b0;
  logic             result_ready = 1'b1;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] high_time;
  logic             result_valid;
  logic             overrun;
  logic             timeout;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // in_clk generator
  logic gen_en    = 1'b0;
  logic gen_level = 1'b0;
  int   gen_p     = 10;
  int   gen_h     = 5;
  int   ph        = 0;

  clock_period_meter #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_clk       (in_clk),
    .enable       (enable),
    .period       (period),
    .high_time    (high_time),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .overrun      (overrun),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (gen_en) begin
      in_clk = (ph < gen_h);
      ph     = (ph + 1 == gen_p) ? 0 : ph + 1;
    end else begin
      in_clk = gen_level;
      ph     = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic wait_valid(input string tag, input int max, output int lat);
    lat = 0;
    do begin
      tick(1);
      lat++;
    end while (result_valid !== 1'b1 && lat < max);
    chk({tag, "_seen"}, {31'd0, result_valid}, 32'd1);
  endtask

  initial begin
    int lat;
    int n;

    // Reset state
    reset = 1'b0;
    tick(3);
    chk("rst_period", {24'd0, period}, 32'd0);
    chk("rst_high", {24'd0, high_time}, 32'd0);
    chk("rst_valid", {31'd0, result_valid}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    reset  = 1'b1;
    enable = 1'b1;
    tick(2);

    // 1: period 10, high 5, ready=1
    gen_p = 10; gen_h = 5; gen_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_valid("t1", 40, lat);
      chk("t1_period", {24'd0, period}, 32'd10);
      chk("t1_high", {24'd0, high_time}, 32'd5);
      tick(1);
    end
    chk("t1_overrun", {31'd0, overrun}, 32'd0);
    chk("t1_timeout", {31'd0, timeout}, 32'd0);

    // 2: ready held low across two captures -> overrun
    wait_valid("t2", 40, lat);
    tick(1);
    result_ready = 1'b0;
    tick(15);
    chk("t2_one_capture_overrun", {31'd0, overrun}, 32'd0);
    chk("t2_one_capture_valid", {31'd0, result_valid}, 32'd1);
    tick(10);
    chk("t2_overrun", {31'd0, overrun}, 32'd1);
    chk("t2_valid_held", {31'd0, result_valid}, 32'd1);
    chk("t2_period_held", {24'd0, period}, 32'd10);
    result_ready = 1'b1;
    tick(1);
    chk("t2_valid_consumed", {31'd0, result_valid}, 32'd0);
    chk("t2_overrun_sticky", {31'd0, overrun}, 32'd1);

    // 5: reset mid-period while in_clk is low
    n = 0;
    while (in_clk !== 1'b1 && n < 20) begin tick(1); n++; end
    n = 0;
    while (in_clk !== 1'b0 && n < 20) begin tick(1); n++; end
    reset = 1'b0;
    tick(1);
    chk("t5_rst_period", {24'd0, period}, 32'd0);
    chk("t5_rst_high", {24'd0, high_time}, 32'd0);
    chk("t5_rst_valid", {31'd0, result_valid}, 32'd0);
    chk("t5_rst_overrun", {31'd0, overrun}, 32'd0);
    chk("t5_rst_timeout", {31'd0, timeout}, 32'd0);
    tick(1);
    reset = 1'b1;
    wait_valid("t5", 60, lat);
    chk("t5_two_rises", {31'd0, (lat >= 10)}, 32'd1);
    chk("t5_period", {24'd0, period}, 32'd10);
    chk("t5_high", {24'd0, high_time}, 32'd5);

    // 6: enable dropped 3 cycles mid-period
    tick(4);
    enable = 1'b0;
    tick(3);
    enable = 1'b1;
    wait_valid("t6", 40, lat);
    chk("t6_latency", lat, 32'd13);
    chk("t6_period", {24'd0, period}, 32'd10);
    chk("t6_high", {24'd0, high_time}, 32'd5);

    // 3: single rise then in_clk stuck low -> timeout after 255 cycles
    reset = 1'b0; gen_en = 1'b0; gen_level = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(2);
    gen_level = 1'b1;
    tick(3);
    gen_level = 1'b0;
    tick(254);
    chk("t3_timeout_early", {31'd0, timeout}, 32'd0);
    tick(1);
    chk("t3_timeout", {31'd0, timeout}, 32'd1);
    chk("t3_no_valid", {31'd0, result_valid}, 32'd0);
    tick(5);
    chk("t3_timeout_sticky", {31'd0, timeout}, 32'd1);

    // 4: period 7, high 3; first result only at the second detected rise
    reset = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(2);
    gen_p = 7; gen_h = 3; gen_en = 1'b1;
    wait_valid("t4", 40, lat);
    chk("t4_latency", lat, 32'd10);
    chk("t4_period", {24'd0, period}, 32'd7);
    chk("t4_high", {24'd0, high_time}, 32'd3);
    tick(1);
    wait_valid("t4b", 20, lat);
    chk("t4b_latency", lat, 32'd6);
    chk("t4b_period", {24'd0, period}, 32'd7);
    chk("t4b_timeout", {31'd0, timeout}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
